// File: rtl/trace_pkg.sv
// trace_pkg: shared FSM encoding, trace-entry layout and entry-width helper for the commit trace buffer.
package trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
  localparam int INST_W = 32;
  localparam int RD_W = 5;
  // Reference layout at XLEN=32; the top re-declares it with its own XLEN in the same field order.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_data;
  } trace_entry_t;
  function automatic int entry_w(input int xlen);
    return 2 * xlen + INST_W + 1 + RD_W;
  endfunction
endpackage

// File: rtl/trace_ring.sv
// trace_ring: circular entry store with occupancy tracking and optional overwrite-oldest on push when full.
module trace_ring #(
  parameter int W = 70,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     overwrite,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_pop, wr, adv;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  // A push into a full ring lands on the oldest slot, so the read side must move past it.
  assign wr = push && (!full || do_pop || overwrite);
  assign adv = do_pop || (wr && full);
  assign dout = empty ? '0 : mem[rptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (adv) rptr <= rptr + 1'b1;
      count <= count + CW'(wr) - CW'(adv);
    end
  always_ff @(posedge clk)
    if (wr && !clr) mem[wptr] <= din;
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: records retired-instruction PC/inst/write-back into a ring, with PC trigger,
// stop/wrap on full, cycle budget with halt request, and a valid/ready drain port.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int CYC_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [XLEN-1:0]        trig_pc,
  input  logic                   wrap_mode,
  input  logic [CYC_W-1:0]       cycle_limit,
  input  logic                   commit_valid,
  input  logic [XLEN-1:0]        commit_pc,
  input  logic [31:0]            commit_inst,
  input  logic                   commit_rd_we,
  input  logic [4:0]             commit_rd,
  input  logic [XLEN-1:0]        commit_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_inst,
  output logic                   out_rd_we,
  output logic [4:0]             out_rd,
  output logic [XLEN-1:0]        out_rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [1:0]             state,
  output logic                   halt_req
);
  localparam int W = entry_w(XLEN);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
  } entry_t;
  state_t st;
  entry_t din, dout;
  logic wrap_q;
  logic [CYC_W-1:0] lim_q, cyc;
  logic [XLEN-1:0] tpc_q;
  logic full, empty, hit, push, lost, budget;
  assign hit = commit_valid && commit_pc == tpc_q;
  assign push = !arm && commit_valid && (st == CAPTURE || (st == ARMED && hit));
  assign lost = push && full && !out_ready;
  assign budget = st == CAPTURE && lim_q != '0 && cyc == lim_q - 1'b1;
  assign din = '{pc: commit_pc, inst: commit_inst, rd_we: commit_rd_we, rd: commit_rd, rd_data: commit_rd_data};
  trace_ring #(.W(W), .DEPTH(DEPTH)) u_ring (
    .clk(clk), .rst(rst), .clr(arm), .push(push), .pop(out_ready), .overwrite(wrap_q),
    .din(din), .dout(dout), .count(count), .full(full), .empty(empty)
  );
  assign out_valid = !empty;
  assign out_pc = dout.pc;
  assign out_inst = dout.inst;
  assign out_rd_we = dout.rd_we;
  assign out_rd = dout.rd;
  assign out_rd_data = dout.rd_data;
  assign state = st;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      wrap_q <= 1'b0;
      lim_q <= '0;
      tpc_q <= '0;
      cyc <= '0;
      overflow <= 1'b0;
      halt_req <= 1'b0;
    end else if (arm) begin
      st <= trig_en ? ARMED : CAPTURE;
      wrap_q <= wrap_mode;
      lim_q <= cycle_limit;
      tpc_q <= trig_pc;
      cyc <= '0;
      overflow <= 1'b0;
      halt_req <= 1'b0;
    end else begin
      if (lost) overflow <= 1'b1;
      if (st == ARMED && hit) st <= CAPTURE;
      if (st == CAPTURE) begin
        cyc <= cyc + 1'b1;
        if (budget) begin
          st <= DONE;
          halt_req <= 1'b1;
        end else if (lost && !wrap_q) st <= DONE;
      end
    end
endmodule
